// File: rtl/uart_rx_deserializer_if.sv
// -----------------------------------------------------------------------------
// uart_rx_deserializer_if
// Purpose : valid/ready byte stream carrying received UART characters from
//           the deserializer to an on-chip consumer.
// Signals :
//   rx_data   DATA_BITS  received character, stable while rx_valid=1
//   rx_valid  1          holding register contains a character
//   rx_ready  1          consumer accepts; transfer when rx_valid & rx_ready
// Modports:
//   master  producer side (the deserializer)
//   slave   consumer side
// -----------------------------------------------------------------------------
interface uart_rx_deserializer_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;

   modport master (
      output rx_data,
      output rx_valid,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      output rx_ready
   );
endinterface

// File: rtl/uart_rx_deserializer.sv
// -----------------------------------------------------------------------------
// uart_rx_deserializer
// Purpose : receives 8N1-style asynchronous serial frames (DATA_BITS data
//           bits, LSB first, one stop bit) and delivers each character on a
//           valid/ready stream through a single holding register.
// Ports   :
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   rxd        in   raw serial line, idle high, asynchronous to clk
//   rx_if      master modport: rx_data / rx_valid out, rx_ready in
//   frame_err  out  1-cycle pulse when the stop bit is sampled low
//   overrun    out  1-cycle pulse when a good character finds the holding
//                   register full and not being drained (character dropped)
//   busy       out  1 while the receive FSM is not in IDLE
// -----------------------------------------------------------------------------
module uart_rx_deserializer #(
   parameter int CLK_HZ    = 50_000_000,
   parameter int BAUD      = 115_200,
   parameter int DATA_BITS = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   rxd,
   uart_rx_deserializer_if.master rx_if,
   output logic                   frame_err,
   output logic                   overrun,
   output logic                   busy
);

   localparam int BIT_CLKS = CLK_HZ / BAUD;
   localparam int CNT_W    = $clog2(BIT_CLKS);
   localparam int IDX_W    = $clog2(DATA_BITS);

   // Half-bit load centres the first sample in the start bit; every later
   // sample is a full bit period after the previous one.
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_CLKS / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_CLKS - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_IDLE = 3'd4
   } state_t;

   logic                 s1_q;
   logic                 s2_q;
   state_t               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [IDX_W-1:0]     idx_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 frame_err_q;
   logic                 busy_q;
   logic [DATA_BITS-1:0] rx_data_q;
   logic                 rx_valid_q;
   logic                 overrun_q;

   logic [DATA_BITS-1:0] rx_data_d;
   logic                 rx_valid_d;
   logic                 overrun_d;
   logic                 frame_good_s;
   logic                 drain_s;
   logic                 load_s;

   // Two-flop synchroniser; preset to the idle level so reset never looks
   // like a start bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
      end else begin
         s1_q <= rxd;
         s2_q <= s1_q;
      end
   end

   // Receive FSM: bit timing, data shifting, frame_err and busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= CNT_ZERO;
         idx_q       <= {IDX_W{1'b0}};
         shift_q     <= {DATA_BITS{1'b0}};
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (!s2_q) begin
                  state_q <= S_START;
                  cnt_q   <= HALF_LOAD;
                  busy_q  <= 1'b1;
               end else begin
                  busy_q  <= 1'b0;
               end
            end
            S_START: begin
               if (cnt_q != CNT_ZERO) begin
                  cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
               end else if (!s2_q) begin
                  state_q <= S_DATA;
                  cnt_q   <= FULL_LOAD;
                  idx_q   <= {IDX_W{1'b0}};
               end else begin
                  // Line was high again at mid-start: a glitch, not a frame.
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            S_DATA: begin
               if (cnt_q != CNT_ZERO) begin
                  cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  shift_q <= {s2_q, shift_q[DATA_BITS-1:1]};
                  cnt_q   <= FULL_LOAD;
                  if (idx_q == LAST_IDX) begin
                     state_q <= S_STOP;
                  end else begin
                     idx_q <= idx_q + IDX_ONE;
                  end
               end
            end
            S_STOP: begin
               if (cnt_q != CNT_ZERO) begin
                  cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
               end else if (s2_q) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  state_q     <= S_WAIT_IDLE;
                  frame_err_q <= 1'b1;
               end
            end
            S_WAIT_IDLE: begin
               // A held-low (break) line must not be taken as a new start bit.
               if (s2_q) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= S_WAIT_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign frame_good_s = (state_q == S_STOP) && (cnt_q == CNT_ZERO) && s2_q;
   assign drain_s      = rx_valid_q && rx_if.rx_ready;
   assign load_s       = frame_good_s && (!rx_valid_q || drain_s);

   // Holding register next state: load, overrun-drop, drain or hold.
   always_comb begin
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      overrun_d  = 1'b0;
      if (load_s) begin
         rx_data_d  = shift_q;
         rx_valid_d = 1'b1;
      end else if (frame_good_s) begin
         overrun_d  = 1'b1;
      end else if (drain_s) begin
         rx_valid_d = 1'b0;
      end else begin
         rx_valid_d = rx_valid_q;
      end
   end

   // Holding register and overrun pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_data_q  <= {DATA_BITS{1'b0}};
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         overrun_q  <= overrun_d;
      end
   end

   assign rx_if.rx_data  = rx_data_q;
   assign rx_if.rx_valid = rx_valid_q;
   assign frame_err      = frame_err_q;
   assign overrun        = overrun_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_rx_deserializer
// Directed bench for uart_rx_deserializer at 16 clocks per bit (10 ns clock,
// 160 ns bit). Expected characters are queued when a frame is sent and popped
// by a monitor on every valid/ready transfer.
// -----------------------------------------------------------------------------
module tb_uart_rx_deserializer;

   localparam int CLK_HZ    = 1_600_000;
   localparam int BAUD      = 100_000;
   localparam int DATA_BITS = 8;
   localparam int BIT_NS    = 160;

   logic clk = 1'b0;
   logic reset;
   logic rxd;
   logic frame_err;
   logic overrun;
   logic busy;

   uart_rx_deserializer_if #(.DATA_BITS(DATA_BITS)) rx_if ();

   uart_rx_deserializer #(
      .CLK_HZ    (CLK_HZ),
      .BAUD      (BAUD),
      .DATA_BITS (DATA_BITS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rxd       (rxd),
      .rx_if     (rx_if),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int hs_cnt = 0;
   int valid_cyc = 0;
   int ferr_cnt = 0;
   int ovr_cnt = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_b;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_counts();
      hs_cnt    = 0;
      valid_cyc = 0;
      ferr_cnt  = 0;
      ovr_cnt   = 0;
   endtask

   task automatic send_frame(input logic [7:0] b, input int bit_ns, input logic stop_bit);
      rxd = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         #(bit_ns);
      end
      rxd = stop_bit;
      #(bit_ns);
   endtask

   // Monitor: count output events and score each transfer against the queue.
   always @(negedge clk) begin
      if (!reset) begin
         if (rx_if.rx_valid) valid_cyc++;
         if (frame_err) ferr_cnt++;
         if (overrun) ovr_cnt++;
         if (frame_err || overrun) begin
            check("ferr_ovr_exclusive", {31'd0, frame_err & overrun}, 32'd0);
         end
         if (rx_if.rx_valid && rx_if.rx_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $error("FAIL unexpected_byte: observed 0x%0h expected none", rx_if.rx_data);
            end else begin
               exp_b = exp_q.pop_front();
               check("rx_data_xfer", {24'd0, rx_if.rx_data}, {24'd0, exp_b});
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      rxd = 1'b1;
      rx_if.rx_ready = 1'b0;
      tick(3);
      check("rst_rx_valid",  {31'd0, rx_if.rx_valid}, 32'd0);
      check("rst_rx_data",   {24'd0, rx_if.rx_data}, 32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      check("rst_overrun",   {31'd0, overrun}, 32'd0);
      check("rst_busy",      {31'd0, busy}, 32'd0);
      reset = 1'b0;
      tick(5);

      // Single good frame, consumer always ready.
      clear_counts();
      rx_if.rx_ready = 1'b1;
      exp_q.push_back(8'h55);
      send_frame(8'h55, BIT_NS, 1'b1);
      tick(40);
      check("t1_transfers",   hs_cnt, 32'd1);
      check("t1_valid_cycles", valid_cyc, 32'd1);
      check("t1_frame_err",   ferr_cnt, 32'd0);
      check("t1_overrun",     ovr_cnt, 32'd0);
      check("t1_queue_empty", exp_q.size(), 32'd0);
      check("t1_busy_idle",   {31'd0, busy}, 32'd0);

      // Two back-to-back frames with the consumer stalled: second one overruns.
      clear_counts();
      rx_if.rx_ready = 1'b0;
      exp_q.push_back(8'hA3);
      send_frame(8'hA3, BIT_NS, 1'b1);
      send_frame(8'h0F, BIT_NS, 1'b1);
      tick(40);
      check("t2_valid_held", {31'd0, rx_if.rx_valid}, 32'd1);
      check("t2_data_held",  {24'd0, rx_if.rx_data}, 32'h0000_00A3);
      check("t2_overrun",    ovr_cnt, 32'd1);
      check("t2_frame_err",  ferr_cnt, 32'd0);
      check("t2_no_xfer",    hs_cnt, 32'd0);
      rx_if.rx_ready = 1'b1;
      tick(1);
      check("t2_valid_drop", {31'd0, rx_if.rx_valid}, 32'd0);
      check("t2_one_xfer",   hs_cnt, 32'd1);

      // Stop bit low, then a held-low break line.
      clear_counts();
      send_frame(8'hFF, BIT_NS, 1'b0);
      tick(40);
      check("t3_busy_break", {31'd0, busy}, 32'd1);
      check("t3_frame_err",  ferr_cnt, 32'd1);
      check("t3_no_valid",   valid_cyc, 32'd0);
      rxd = 1'b1;
      tick(10);
      check("t3_busy_released", {31'd0, busy}, 32'd0);
      check("t3_frame_err_once", ferr_cnt, 32'd1);
      check("t3_no_xfer",    hs_cnt, 32'd0);
      check("t3_overrun",    ovr_cnt, 32'd0);

      // Short low glitch on an idle line.
      clear_counts();
      rxd = 1'b0;
      tick(4);
      check("t4_busy_glitch", {31'd0, busy}, 32'd1);
      rxd = 1'b1;
      tick(40);
      check("t4_busy_idle", {31'd0, busy}, 32'd0);
      check("t4_no_valid",  valid_cyc, 32'd0);
      check("t4_frame_err", ferr_cnt, 32'd0);

      // Sender bit period skewed fast and slow around the nominal 16 clocks.
      clear_counts();
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 155, 1'b1);
      tick(30);
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 165, 1'b1);
      tick(30);
      check("t5_transfers",   hs_cnt, 32'd2);
      check("t5_frame_err",   ferr_cnt, 32'd0);
      check("t5_queue_empty", exp_q.size(), 32'd0);

      // Reset in the middle of data bit 4 of 0x81, then a clean frame.
      clear_counts();
      rxd = 1'b0;
      #(BIT_NS);
      rxd = 1'b1;
      #(BIT_NS);
      rxd = 1'b0;
      #(BIT_NS * 3);
      #(BIT_NS + BIT_NS / 2);
      tick(1);
      check("t6_busy_mid", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      rxd = 1'b1;
      tick(1);
      check("t6_rst_busy",      {31'd0, busy}, 32'd0);
      check("t6_rst_rx_valid",  {31'd0, rx_if.rx_valid}, 32'd0);
      check("t6_rst_rx_data",   {24'd0, rx_if.rx_data}, 32'd0);
      check("t6_rst_frame_err", {31'd0, frame_err}, 32'd0);
      check("t6_rst_overrun",   {31'd0, overrun}, 32'd0);
      reset = 1'b0;
      tick(10);
      exp_q.push_back(8'h42);
      send_frame(8'h42, BIT_NS, 1'b1);
      tick(40);
      check("t6_transfers",   hs_cnt, 32'd1);
      check("t6_frame_err",   ferr_cnt, 32'd0);
      check("t6_queue_empty", exp_q.size(), 32'd0);
      check("t6_busy_idle",   {31'd0, busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
